// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: opcodes, FSM states,
// forwarding encodings and scoreboard slot layouts.
package hazard_ctrl_pkg;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpJal   = 6'b000011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpSlti  = 6'b001010;
  localparam logic [5:0] OpAndi  = 6'b001100;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;

  localparam logic [5:0] FnJr    = 6'b001000;
  localparam logic [5:0] FnJalr  = 6'b001001;

  typedef enum logic [1:0] {
    StRun,
    StLdStall,
    StFreeze
  } state_e;

  localparam logic [1:0] FwdRf    = 2'b00;
  localparam logic [1:0] FwdExMem = 2'b01;
  localparam logic [1:0] FwdMemWb = 2'b10;

  typedef struct packed {
    logic       valid;
    logic [4:0] dst;
    logic       is_load;
  } slot_t;

  // EX additionally remembers its source registers for forwarding.
  typedef struct packed {
    slot_t      slot;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       re1;
    logic       re2;
  } ex_slot_t;

endpackage

// File: rtl/dst_decode.sv
// Destination-register decode for one instruction; $0 never counts as a destination.
module dst_decode
  import hazard_ctrl_pkg::*;
(
  input  logic [31:0] ir_i,
  output logic        valid_o,
  output logic [4:0]  dst_o,
  output logic        is_load_o
);

  logic [5:0] op;
  logic [5:0] fn;
  logic [4:0] dst_raw;
  logic       has_dst;
  logic       unused_ir;

  assign op        = ir_i[31:26];
  assign fn        = ir_i[5:0];
  assign unused_ir = ^{ir_i[25:21], ir_i[10:6]};

  // Pick the written register field by instruction class.
  always_comb begin
    has_dst   = 1'b0;
    dst_raw   = 5'd0;
    is_load_o = 1'b0;
    case (op)
      OpRtype: begin
        has_dst = (fn != FnJr);
        dst_raw = ir_i[15:11];
      end
      OpLw: begin
        has_dst   = 1'b1;
        dst_raw   = ir_i[20:16];
        is_load_o = 1'b1;
      end
      OpAddi, OpAndi, OpOri, OpSlti: begin
        has_dst = 1'b1;
        dst_raw = ir_i[20:16];
      end
      OpJal: begin
        has_dst = 1'b1;
        dst_raw = 5'd31;
      end
      default: ;
    endcase
  end

  assign valid_o = has_dst && (dst_raw != 5'd0);
  assign dst_o   = valid_o ? dst_raw : 5'd0;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, memory freeze, branch/jump flush,
// EX operand forwarding and a saturating stall-cycle counter.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [31:0]            id_ir,
  input  logic                   id_re1,
  input  logic                   id_re2,
  input  logic                   br_taken_ex,
  input  logic                   mem_busy,
  output logic                   pc_we,
  output logic                   ifid_we,
  output logic                   idex_bubble,
  output logic                   ifid_flush,
  output logic [1:0]             fwd_a,
  output logic [1:0]             fwd_b,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  state_e                 state_q, state_d;
  ex_slot_t               ex_q, ex_d;
  slot_t                  mem_q, mem_d;
  slot_t                  wb_q, wb_d;
  logic [STALL_CNT_W-1:0] cnt_q, cnt_d;

  logic       id_valid;
  logic [4:0] id_dst;
  logic       id_is_load;
  logic       id_is_jump;
  logic       lu_hazard;
  logic       unused_wb_load;

  dst_decode u_dst_decode (
    .ir_i      (id_ir),
    .valid_o   (id_valid),
    .dst_o     (id_dst),
    .is_load_o (id_is_load)
  );

  assign id_is_jump     = (id_ir[31:26] == OpJ) || (id_ir[31:26] == OpJal);
  assign unused_wb_load = wb_q.is_load;

  // LDSTALL always follows a bubble into EX, so no hazard can be seen there.
  assign lu_hazard = (state_q != StLdStall) && ex_q.slot.valid && ex_q.slot.is_load &&
                     ((id_re1 && (id_ir[25:21] == ex_q.slot.dst)) ||
                      (id_re2 && (id_ir[20:16] == ex_q.slot.dst)));

  // Pipeline control; reset forces the idle "everything flows" pattern.
  always_comb begin
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    if (rst_n) begin
      if (mem_busy) begin
        pc_we   = 1'b0;
        ifid_we = 1'b0;
      end else if (br_taken_ex) begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end else if (lu_hazard) begin
        pc_we       = 1'b0;
        ifid_we     = 1'b0;
        idex_bubble = 1'b1;
      end else if (id_is_jump) begin
        ifid_flush = 1'b1;
      end
    end
  end

  // Next FSM state, scoreboard shift and stall counter.
  always_comb begin
    state_d = StRun;
    ex_d    = ex_q;
    mem_d   = mem_q;
    wb_d    = wb_q;
    cnt_d   = cnt_q;
    if (mem_busy) begin
      state_d = StFreeze;
    end else begin
      if (lu_hazard && !br_taken_ex) state_d = StLdStall;
      wb_d  = mem_q;
      mem_d = ex_q.slot;
      if (idex_bubble) begin
        ex_d = '0;
      end else begin
        ex_d.slot.valid   = id_valid;
        ex_d.slot.dst     = id_dst;
        ex_d.slot.is_load = id_is_load;
        ex_d.rs           = id_ir[25:21];
        ex_d.rt           = id_ir[20:16];
        ex_d.re1          = id_re1;
        ex_d.re2          = id_re2;
      end
    end
    if (!pc_we && (cnt_q != {STALL_CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Forwarding selects straight from the scoreboard; MEM beats WB.
  always_comb begin
    fwd_a = FwdRf;
    fwd_b = FwdRf;
    if (mem_q.valid && !mem_q.is_load && ex_q.re1 && (mem_q.dst == ex_q.rs)) begin
      fwd_a = FwdExMem;
    end else if (wb_q.valid && ex_q.re1 && (wb_q.dst == ex_q.rs)) begin
      fwd_a = FwdMemWb;
    end
    if (mem_q.valid && !mem_q.is_load && ex_q.re2 && (mem_q.dst == ex_q.rt)) begin
      fwd_b = FwdExMem;
    end else if (wb_q.valid && ex_q.re2 && (wb_q.dst == ex_q.rt)) begin
      fwd_b = FwdMemWb;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
      cnt_q   <= cnt_d;
    end
  end

  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: the stimulus process pushes the reference
// model's expected outputs per cycle, a monitor pops and compares on negedge.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [31:0] id_ir;
  logic        id_re1, id_re2, br_taken_ex, mem_busy;
  logic        pc_we, ifid_we, idex_bubble, ifid_flush;
  logic [1:0]  fwd_a, fwd_b;
  logic [15:0] stall_cnt;

  hazard_ctrl #(.STALL_CNT_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_ir       (id_ir),
    .id_re1      (id_re1),
    .id_re2      (id_re2),
    .br_taken_ex (br_taken_ex),
    .mem_busy    (mem_busy),
    .pc_we       (pc_we),
    .ifid_we     (ifid_we),
    .idex_bubble (idex_bubble),
    .ifid_flush  (ifid_flush),
    .fwd_a       (fwd_a),
    .fwd_b       (fwd_b),
    .stall_cnt   (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         chk;
    logic       pc_we, ifid_we, bub, flush;
    logic [1:0] fa, fb;
    int         cnt;
    logic [2:0] slots;
    int         st;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model: in-flight instructions as (dst or -1, is_load); EX sources or -1.
  int     p_dst[3];
  bit     p_ld[3];
  int     ex_rs, ex_rt, m_cnt;
  state_e m_state;

  localparam logic [31:0] NOP = 32'h0;

  function automatic logic [31:0] r_ins(input int rs, input int rt, input int rd,
                                        input logic [5:0] fn);
    return {6'b000000, 5'(rs), 5'(rt), 5'(rd), 5'b00000, fn};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input int rs, input int rt);
    return {op, 5'(rs), 5'(rt), 16'h0004};
  endfunction

  function automatic int dst_of(input logic [31:0] ir);
    int d;
    case (ir[31:26])
      6'd0:                        d = (ir[5:0] == 6'b001000) ? -1 : int'(ir[15:11]);
      6'd35, 6'd8, 6'd12, 6'd13, 6'd10: d = int'(ir[20:16]);
      6'd3:                        d = 31;
      default:                     d = -1;
    endcase
    return (d == 0) ? -1 : d;
  endfunction

  function automatic logic [1:0] fwd_of(input int src);
    if (p_dst[1] >= 0 && !p_ld[1] && src == p_dst[1]) return 2'b01;
    if (p_dst[2] >= 0 && src == p_dst[2]) return 2'b10;
    return 2'b00;
  endfunction

  task automatic cmp(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, got, want);
    end
  endtask

  // Monitor: compares whatever the stimulus side predicted for this cycle.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      if (mon_e.chk) begin
        cmp("pc_we", int'(pc_we), int'(mon_e.pc_we));
        cmp("ifid_we", int'(ifid_we), int'(mon_e.ifid_we));
        cmp("idex_bubble", int'(idex_bubble), int'(mon_e.bub));
        cmp("ifid_flush", int'(ifid_flush), int'(mon_e.flush));
        cmp("fwd_a", int'(fwd_a), int'(mon_e.fa));
        cmp("fwd_b", int'(fwd_b), int'(mon_e.fb));
        cmp("stall_cnt", int'(stall_cnt), mon_e.cnt);
        cmp("slots_valid", int'({dut.ex_q.slot.valid, dut.mem_q.valid, dut.wb_q.valid}),
            int'(mon_e.slots));
        cmp("fsm_state", int'(dut.state_q), mon_e.st);
      end
    end
  end

  // One cycle: drive inputs, predict outputs, then advance the model at the edge.
  task automatic step(input logic [31:0] ir, input logic re1, input logic re2,
                      input logic br, input logic mb, input bit rst, input bit chk);
    exp_t e;
    int   d, rs, rt;
    bit   ld, jmp, haz;
    bit   stall = 1'b0;
    id_ir = ir; id_re1 = re1; id_re2 = re2; br_taken_ex = br; mem_busy = mb;
    rst_n = !rst;
    if (rst) begin
      p_dst = '{-1, -1, -1};
      p_ld  = '{0, 0, 0};
      ex_rs = -1; ex_rt = -1; m_cnt = 0; m_state = StRun;
    end
    d   = dst_of(ir);
    ld  = (ir[31:26] == 6'd35);
    jmp = (ir[31:26] == 6'd2) || (ir[31:26] == 6'd3);
    rs  = re1 ? int'(ir[25:21]) : -1;
    rt  = re2 ? int'(ir[20:16]) : -1;
    haz = (p_dst[0] >= 0) && p_ld[0] && (rs == p_dst[0] || rt == p_dst[0]);
    e.chk   = chk;
    e.cnt   = m_cnt;
    e.st    = int'(m_state);
    e.slots = {p_dst[0] >= 0, p_dst[1] >= 0, p_dst[2] >= 0};
    e.fa    = fwd_of(ex_rs);
    e.fb    = fwd_of(ex_rt);
    if (rst) begin
      e.pc_we = 1'b1; e.ifid_we = 1'b1; e.bub = 1'b0; e.flush = 1'b0;
    end else begin
      stall   = mb || (haz && !br);
      e.pc_we = !stall; e.ifid_we = !stall;
      e.bub   = !mb && (br || haz);
      e.flush = !mb && (br || (jmp && !haz));
    end
    exp_q.push_back(e);
    @(posedge clk);
    if (!rst) begin
      if (stall && m_cnt < 65535) m_cnt++;
      m_state = mb ? StFreeze : ((haz && !br) ? StLdStall : StRun);
      if (!mb) begin
        p_dst[2] = p_dst[1]; p_ld[2] = p_ld[1];
        p_dst[1] = p_dst[0]; p_ld[1] = p_ld[0];
        if (e.bub) begin
          p_dst[0] = -1; p_ld[0] = 1'b0; ex_rs = -1; ex_rt = -1;
        end else begin
          p_dst[0] = d; p_ld[0] = ld; ex_rs = rs; ex_rt = rt;
        end
      end
    end
    #1;
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) step(NOP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic rand_cycle();
    logic [31:0] ir;
    logic        r1, r2;
    int          k  = $urandom_range(0, 9);
    int          rs = $urandom_range(0, 7);
    int          rt = $urandom_range(0, 7);
    int          rd = $urandom_range(0, 7);
    case (k)
      0, 1:    begin ir = r_ins(rs, rt, rd, 6'h20); r1 = 1'b1; r2 = 1'b1; end
      2:       begin ir = r_ins(rs, 0, 0, 6'h08);   r1 = 1'b1; r2 = 1'b0; end
      3, 4:    begin ir = i_ins(6'd35, rs, rt);     r1 = 1'b1; r2 = 1'b0; end
      5:       begin ir = i_ins(6'd8, rs, rt);      r1 = 1'b1; r2 = 1'b0; end
      6:       begin ir = i_ins(6'd43, rs, rt);     r1 = 1'b1; r2 = 1'b1; end
      7:       begin ir = i_ins(6'd4, rs, rt);      r1 = 1'b1; r2 = 1'b1; end
      8:       begin ir = {6'd3, 26'h10};           r1 = 1'b0; r2 = 1'b0; end
      default: begin ir = {6'd2, 26'h10};           r1 = 1'b0; r2 = 1'b0; end
    endcase
    step(ir, r1, r2, ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0), 1'b0, 1'b1);
  endtask

  logic [31:0] lw8, add9;

  initial begin
    rst_n = 1'b1; id_ir = NOP; id_re1 = 1'b0; id_re2 = 1'b0;
    br_taken_ex = 1'b0; mem_busy = 1'b0;
    lw8  = i_ins(6'd35, 1, 8);
    add9 = r_ins(8, 10, 9, 6'h20);
    @(posedge clk);
    #1;
    step(NOP, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    step(NOP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    nops(2);
    // Load-use: one stall, then MEM/WB forwarding two cycles on.
    step(lw8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(add9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(add9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    nops(3);
    // Back-to-back ALU dependency through EX/MEM on both operands.
    step(r_ins(1, 2, 8, 6'h20), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(r_ins(8, 8, 9, 6'h22), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    nops(3);
    // Writes to $0 never forward.
    step(r_ins(1, 2, 0, 6'h20), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(r_ins(0, 0, 3, 6'h20), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    nops(3);
    // Jumps flush IF/ID.
    step({6'd2, 26'h40}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step({6'd3, 26'h40}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    nops(3);
    // Taken branch beats a simultaneous load-use hazard.
    step(lw8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(add9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    nops(3);
    // Memory busy for three cycles starting in LDSTALL.
    step(lw8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(add9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(add9, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    step(add9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    nops(3);
    // Drive the counter into saturation, then keep stalling.
    for (int i = 0; i < 65540; i++) step(NOP, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, (i >= 65530));
    step(lw8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(add9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(add9, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    nops(2);
    // Reset lands in the middle of a freeze.
    step(r_ins(1, 2, 8, 6'h20), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(NOP, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    step(NOP, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    step(NOP, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    step(NOP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    nops(1);
    for (int i = 0; i < 500; i++) rand_cycle();
    nops(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
